// File: rtl/svm_pkg.sv
// rtl/svm_pkg.sv - shared types and width helpers for the sequential one-vs-rest SVM core
// Purpose: FSM state encoding plus constant functions used to size datapaths.
// Ports: none (package).
package svm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  // Wide enough for bias plus the sum of N_FEATURES worst-case products,
  // so the accumulator can never overflow.
  function automatic int acc_width(input int feature_bits, input int weight_width,
                                   input int bias_width, input int n_features);
    int pw;
    int m;
    pw = feature_bits + weight_width + 1;
    m  = (bias_width > pw) ? bias_width : pw;
    return m + $clog2(n_features + 1) + 1;
  endfunction

endpackage

// File: rtl/seq_svm_ovr_core_if.sv
// rtl/seq_svm_ovr_core_if.sv - request/result bundle for the SVM classifier core
// Purpose: groups the feature vector, start/abort controls and classification result.
// Signals: in (features), start, abort (master -> core); busy, ready, w_class, score (core -> master).
interface seq_svm_ovr_core_if
  import svm_pkg::*;
#(
  parameter int N_FEATURES   = 11,
  parameter int FEATURE_BITS = 4,
  parameter int N_CLASSES    = 6,
  parameter int WEIGHT_WIDTH = 6,
  parameter int BIAS_WIDTH   = 6
) ();

  localparam int ACC_W = acc_width(FEATURE_BITS, WEIGHT_WIDTH, BIAS_WIDTH, N_FEATURES);
  localparam int CW    = $clog2(N_CLASSES);

  logic [N_FEATURES*FEATURE_BITS-1:0] in;
  logic                               start;
  logic                               abort;
  logic                               busy;
  logic                               ready;
  logic [CW-1:0]                      w_class;
  logic signed [ACC_W-1:0]            score;

  modport master (
    output in, start, abort,
    input  busy, ready, w_class, score
  );

  modport slave (
    input  in, start, abort,
    output busy, ready, w_class, score
  );

endinterface

// File: rtl/svm_mac_lanes.sv
// rtl/svm_mac_lanes.sv - LANES-wide signed multiply and sum for one feature group
// Purpose: combinational partial sum of feature*weight over the lanes of the current group.
// Ports: feat (latched features), cls (class index), grp (group index) in; psum (signed group sum) out.
module svm_mac_lanes
  import svm_pkg::*;
#(
  parameter int N_FEATURES   = 11,
  parameter int FEATURE_BITS = 4,
  parameter int N_CLASSES    = 6,
  parameter int WEIGHT_WIDTH = 6,
  parameter int LANES        = 1,
  parameter int ACC_W        = 16,
  parameter int CW           = 3,
  parameter int GW           = 4,
  parameter logic [N_CLASSES*N_FEATURES*WEIGHT_WIDTH-1:0] WEIGHTS = '0
) (
  input  logic [N_FEATURES*FEATURE_BITS-1:0] feat,
  input  logic [CW-1:0]                      cls,
  input  logic [GW-1:0]                      grp,
  output logic signed [ACC_W-1:0]            psum
);

  localparam int PW = FEATURE_BITS + WEIGHT_WIDTH + 1;

  logic signed [ACC_W-1:0] lane_term [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [31:0]                    fi;
    logic [FEATURE_BITS-1:0]        f;
    logic signed [WEIGHT_WIDTH-1:0] w;
    logic signed [PW-1:0]           p;

    // Shifts instead of indexed part-selects keep index widths free and
    // simply yield zero past the end of the vectors.
    always_comb begin
      fi = 32'(grp) * 32'(LANES) + 32'(l);
      f  = FEATURE_BITS'(feat >> (fi * 32'(FEATURE_BITS)));
      w  = WEIGHT_WIDTH'(WEIGHTS >> ((32'(cls) * 32'(N_FEATURES) + fi) * 32'(WEIGHT_WIDTH)));
      p  = $signed({1'b0, f}) * w;
      // Lanes past the last feature in a ragged group contribute nothing.
      lane_term[l] = (fi < 32'(N_FEATURES)) ? {{(ACC_W-PW){p[PW-1]}}, p} : '0;
    end
  end

  always_comb begin
    psum = '0;
    for (int l = 0; l < LANES; l++) begin
      psum = psum + lane_term[l];
    end
  end

endmodule

// File: rtl/seq_svm_ovr_core.sv
// rtl/seq_svm_ovr_core.sv - sequential one-vs-rest linear SVM with start/ready handshake
// Purpose: accumulates each class score over feature groups, argmax-selects the winner.
// Ports: clk, rst_n (async active-low); bus (slave): in, start, abort -> busy, ready, w_class, score.
module seq_svm_ovr_core
  import svm_pkg::*;
#(
  parameter int N_FEATURES   = 11,
  parameter int FEATURE_BITS = 4,
  parameter int N_CLASSES    = 6,
  parameter int WEIGHT_WIDTH = 6,
  parameter int BIAS_WIDTH   = 6,
  parameter int LANES        = 1,
  parameter logic [N_CLASSES*N_FEATURES*WEIGHT_WIDTH-1:0] WEIGHTS = '0,
  parameter logic [N_CLASSES*BIAS_WIDTH-1:0]              BIASES  = '0
) (
  input logic               clk,
  input logic               rst_n,
  seq_svm_ovr_core_if.slave bus
);

  localparam int ACC_W = acc_width(FEATURE_BITS, WEIGHT_WIDTH, BIAS_WIDTH, N_FEATURES);
  localparam int G     = ceil_div(N_FEATURES, LANES);
  localparam int GW    = clog2_min1(G);
  localparam int CW    = $clog2(N_CLASSES);
  localparam int FW    = N_FEATURES * FEATURE_BITS;

  state_e                  state_q, state_d;
  logic [FW-1:0]           feat_q, feat_d;
  logic [CW-1:0]           cls_q, cls_d;
  logic [GW-1:0]           grp_q, grp_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] best_q, best_d;
  logic [CW-1:0]           best_idx_q, best_idx_d;
  logic [CW-1:0]           w_class_q, w_class_d;
  logic signed [ACC_W-1:0] score_q, score_d;

  logic signed [ACC_W-1:0] psum;
  logic                    take;
  logic                    last_cls;
  logic                    last_grp;

  function automatic logic signed [ACC_W-1:0] bias_ext(input logic [CW-1:0] c);
    logic [BIAS_WIDTH-1:0] b;
    b = BIAS_WIDTH'(BIASES >> (32'(c) * 32'(BIAS_WIDTH)));
    return {{(ACC_W-BIAS_WIDTH){b[BIAS_WIDTH-1]}}, b};
  endfunction

  svm_mac_lanes #(
    .N_FEATURES  (N_FEATURES),
    .FEATURE_BITS(FEATURE_BITS),
    .N_CLASSES   (N_CLASSES),
    .WEIGHT_WIDTH(WEIGHT_WIDTH),
    .LANES       (LANES),
    .ACC_W       (ACC_W),
    .CW          (CW),
    .GW          (GW),
    .WEIGHTS     (WEIGHTS)
  ) u_mac (
    .feat(feat_q),
    .cls (cls_q),
    .grp (grp_q),
    .psum(psum)
  );

  assign last_cls = (cls_q == CW'(N_CLASSES - 1));
  assign last_grp = (grp_q == GW'(G - 1));
  // Strict compare keeps the lower index on ties; class 0 always seeds best.
  assign take     = (cls_q == '0) || (acc_q > best_q);

  always_comb begin
    state_d    = state_q;
    feat_d     = feat_q;
    cls_d      = cls_q;
    grp_d      = grp_q;
    acc_d      = acc_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    w_class_d  = w_class_q;
    score_d    = score_q;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          feat_d  = bus.in;
          cls_d   = '0;
          grp_d   = '0;
          acc_d   = bias_ext('0);
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_q + psum;
        if (last_grp) begin
          state_d = CMP;
        end else begin
          grp_d = grp_q + GW'(1);
        end
      end
      CMP: begin
        if (take) begin
          best_d     = acc_q;
          best_idx_d = cls_q;
        end
        if (last_cls) begin
          // Result registers load here so they are valid during DONE.
          w_class_d = take ? cls_q : best_idx_q;
          score_d   = take ? acc_q : best_q;
          state_d   = DONE;
        end else begin
          cls_d   = cls_q + CW'(1);
          grp_d   = '0;
          acc_d   = bias_ext(cls_q + CW'(1));
          state_d = ACC;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort drops the computation and leaves the previous result untouched.
    if (bus.abort && state_q != IDLE) begin
      state_d   = IDLE;
      w_class_d = w_class_q;
      score_d   = score_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      feat_q     <= '0;
      cls_q      <= '0;
      grp_q      <= '0;
      acc_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      w_class_q  <= '0;
      score_q    <= '0;
    end else begin
      state_q    <= state_d;
      feat_q     <= feat_d;
      cls_q      <= cls_d;
      grp_q      <= grp_d;
      acc_q      <= acc_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      w_class_q  <= w_class_d;
      score_q    <= score_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.ready   = (state_q == DONE);
  assign bus.w_class = w_class_q;
  assign bus.score   = score_q;

endmodule
